// File: rtl/step_rate_ramp_pkg.sv
// step_rate_ramp_pkg
//   Definitions shared by the ramp FSM and its serial divider.
//   The state set is reused by the planned multi-axis sequencer, so keep the
//   encoding stable.
//   Contents: ramp_state_t (IDLE/UPDATE/DIVIDE/LOAD), period_stop() helper.
package step_rate_ramp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_LOAD   = 2'd3
    } ramp_state_t;

    // Largest positive period value; the step generator treats it as "stopped".
    function automatic longint period_stop(input int bits);
        return (64'sd1 <<< (bits - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/step_rate_ramp_serial_divider.sv
// step_rate_ramp_serial_divider
//   Unsigned restoring divider. It produces one quotient bit per clock, so
//   it is busy for N cycles after start.
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     start               load operands and begin (ignored results if busy)
//     dividend [N]        numerator
//     divisor  [D]        denominator (0 yields an all-ones quotient)
//     busy                iteration in progress
//     done                one-cycle pulse, quotient valid from this cycle on
//     quotient [N]        floor(dividend / divisor)
module step_rate_ramp_serial_divider #(
    parameter int N = 32,
    parameter int D = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient
);

    localparam int CW = $clog2(N + 1);

    // dq_q starts as the dividend and fills with quotient bits from the right.
    logic [N-1:0]  dq_q, dq_d;
    logic [D-1:0]  rem_q, rem_d;
    logic [D-1:0]  dsr_q, dsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [D:0] rem_sh;
    logic [D:0] rem_sub;
    logic       fits;

    always_comb begin
        rem_sh  = {rem_q, dq_q[N-1]};
        rem_sub = rem_sh - {1'b0, dsr_q};
        fits    = (rem_sh >= {1'b0, dsr_q});

        dq_d   = dq_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start) begin
            dq_d   = dividend;
            rem_d  = '0;
            dsr_d  = divisor;
            cnt_d  = CW'(N);
            busy_d = 1'b1;
        end else if (busy_q) begin
            dq_d  = {dq_q[N-2:0], fits};
            // The partial remainder stays below the divisor, so D bits hold it.
            rem_d = fits ? D'(rem_sub) : D'(rem_sh);
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dq_q   <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dq_q   <= dq_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = dq_q;

endmodule

// File: rtl/step_rate_ramp.sv
// step_rate_ramp
//   Acceleration-limited velocity ramp for one step_pulse_generator channel.
//   On every ramp tick, current_velocity moves toward the target by accel.
//   The new velocity is then converted to a clock-tick period and direction.
//
//   state  | meaning
//   IDLE   | wait for ramp tick
//   UPDATE | step current_velocity toward effective target, start divide
//   DIVIDE | serial CLK_HZ / |v| in progress
//   LOAD   | publish period and dir together
//
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     enable            0 forces the effective target to 0
//     target_velocity   signed commanded velocity (steps/s)
//     accel             unsigned velocity change per ramp tick
//     period            clk cycles per step (PERIOD_STOP when stopped)
//     dir               1 positive, 0 negative
//     current_velocity  signed present ramp velocity
//     at_speed          current_velocity equals effective target (registered)
module step_rate_ramp
    import step_rate_ramp_pkg::*;
#(
    parameter int PERIOD_BITS = 32,
    parameter int VEL_BITS    = 24,
    parameter int CLK_HZ      = 50_000_000,
    parameter int RAMP_DIV    = 50_000,
    parameter int MAX_VEL     = 200_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [VEL_BITS-1:0]    target_velocity,
    input  logic [VEL_BITS-1:0]    accel,
    output logic [PERIOD_BITS-1:0] period,
    output logic                   dir,
    output logic [VEL_BITS-1:0]    current_velocity,
    output logic                   at_speed
);

    // Two guard bits: |v| + accel can exceed the VEL_BITS signed range.
    localparam int IW = VEL_BITS + 2;
    localparam int CW = $clog2(RAMP_DIV);
    localparam logic [PERIOD_BITS-1:0] PERIOD_STOP = PERIOD_BITS'(period_stop(PERIOD_BITS));
    localparam logic signed [IW-1:0]   MAX_X       = IW'(MAX_VEL);

    ramp_state_t                 state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic signed [VEL_BITS-1:0]  vel_q, vel_d;
    logic [PERIOD_BITS-1:0]      period_q, period_d;
    logic                        dir_q, dir_d;
    logic                        at_speed_q, at_speed_d;

    logic                        tick;
    logic signed [IW-1:0]        cur_x, tgt_x, sat_x, eff_x, acc_x, step_x;
    logic [IW-1:0]               step_mag;
    logic                        div_start, div_busy, div_done;
    logic [PERIOD_BITS-1:0]      div_quot;

    always_comb begin
        tick  = (cnt_q == CW'(RAMP_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;

        cur_x = IW'(vel_q);
        tgt_x = IW'($signed(target_velocity));
        acc_x = {2'b00, accel};

        if (tgt_x > MAX_X)       sat_x = MAX_X;
        else if (tgt_x < -MAX_X) sat_x = -MAX_X;
        else                     sat_x = tgt_x;
        eff_x = enable ? sat_x : '0;

        // Saturating step toward eff_x; a sign change stops at zero for one tick.
        step_x = cur_x;
        if (cur_x < eff_x) begin
            step_x = cur_x + acc_x;
            if (step_x > eff_x) step_x = eff_x;
            if (cur_x[IW-1] && !step_x[IW-1] && step_x != '0) step_x = '0;
        end else if (cur_x > eff_x) begin
            step_x = cur_x - acc_x;
            if (step_x < eff_x) step_x = eff_x;
            if (!cur_x[IW-1] && cur_x != '0 && step_x[IW-1]) step_x = '0;
        end
        step_mag  = step_x[IW-1] ? -step_x : step_x;
        div_start = (state_q == ST_UPDATE);

        state_d    = state_q;
        vel_d      = vel_q;
        period_d   = period_q;
        dir_d      = dir_q;
        at_speed_d = (cur_x == eff_x);

        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                vel_d   = VEL_BITS'(step_x);
                state_d = ST_DIVIDE;
            end
            ST_DIVIDE: begin
                if (div_done) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (vel_q == '0) begin
                    period_d = PERIOD_STOP;
                end else begin
                    period_d = (div_quot > PERIOD_STOP) ? PERIOD_STOP : div_quot;
                    dir_d    = !vel_q[VEL_BITS-1];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            vel_q      <= '0;
            period_q   <= PERIOD_STOP;
            dir_q      <= 1'b0;
            at_speed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vel_q      <= vel_d;
            period_q   <= period_d;
            dir_q      <= dir_d;
            at_speed_q <= at_speed_d;
        end
    end

    step_rate_ramp_serial_divider #(
        .N (PERIOD_BITS),
        .D (VEL_BITS)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (PERIOD_BITS'(CLK_HZ)),
        .divisor  (VEL_BITS'(step_mag)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // RAMP_DIV must leave room for a full UPDATE/DIVIDE/LOAD pass between ticks.
    a_tick_in_idle: assert property (@(posedge clk) disable iff (reset)
        tick |-> (state_q == ST_IDLE));
    a_load_after_div: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_LOAD) |-> !div_busy);

    assign period           = period_q;
    assign dir              = dir_q;
    assign current_velocity = vel_q;
    assign at_speed         = at_speed_q;

endmodule

// File: tb/tb_step_rate_ramp.sv
// tb_step_rate_ramp
//   Directed ramp scenarios with literal expectations, then random commands.
//   A cycle-level behavioural model of the ramp is compared against the DUT
//   on every cycle.
module tb_step_rate_ramp;

    localparam int     PB     = 32;
    localparam int     VB     = 24;
    localparam int     CLK_HZ = 50_000_000;
    localparam int     RD     = 40;
    localparam int     MAXV   = 200_000;
    localparam longint STOP   = 64'd2147483647;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [VB-1:0] target_velocity = 24'd1000;
    logic [VB-1:0] accel = 24'd100;
    logic [PB-1:0] period;
    logic          dir;
    logic [VB-1:0] current_velocity;
    logic          at_speed;

    step_rate_ramp #(
        .PERIOD_BITS (PB),
        .VEL_BITS    (VB),
        .CLK_HZ      (CLK_HZ),
        .RAMP_DIV    (RD),
        .MAX_VEL     (MAXV)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .target_velocity  (target_velocity),
        .accel            (accel),
        .period           (period),
        .dir              (dir),
        .current_velocity (current_velocity),
        .at_speed         (at_speed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    int     n = 0;          // rising edges since reset release
    int     m_vel = 0;
    longint m_period = STOP;
    bit     m_dir = 1'b0;
    bit     m_at = 1'b0;
    int     pend_n = -1;
    int     pend_v = 0;

    function automatic int eff_of(input bit en, input logic [VB-1:0] t);
        int tv;
        tv = int'($signed(t));
        if (!en) return 0;
        if (tv > MAXV) return MAXV;
        if (tv < -MAXV) return -MAXV;
        return tv;
    endfunction

    function automatic int ramp_step(input int v, input int e, input int a);
        int nv;
        if (e > v) nv = (v + a > e) ? e : v + a;
        else       nv = (v - a < e) ? e : v - a;
        if ((v > 0 && nv < 0) || (v < 0 && nv > 0)) nv = 0;
        return nv;
    endfunction

    function automatic longint period_of(input int v);
        longint q;
        if (v == 0) return STOP;
        q = longint'(CLK_HZ) / longint'(v < 0 ? -v : v);
        return (q > STOP) ? STOP : q;
    endfunction

    // Tick k wraps at edge k*RD; velocity shows at +1, period/dir at +PB+3.
    always @(posedge clk or posedge reset) begin
        int e;
        if (reset) begin
            n = 0; m_vel = 0; m_period = STOP; m_dir = 1'b0; m_at = 1'b0; pend_n = -1;
        end else begin
            e = eff_of(enable, target_velocity);
            m_at = (m_vel == e);
            n = n + 1;
            if (n > 1 && (n % RD) == 1) begin
                m_vel  = ramp_step(m_vel, e, int'(accel));
                pend_n = n + PB + 2;
                pend_v = m_vel;
            end
            if (n == pend_n) begin
                m_period = period_of(pend_v);
                if (pend_v > 0) m_dir = 1'b1;
                else if (pend_v < 0) m_dir = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s edge=%0d got %0d expected %0d", name, n, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("cyc_period", longint'(period), m_period);
            chk("cyc_dir", longint'(dir), longint'(m_dir));
            chk("cyc_vel", longint'($signed(current_velocity)), longint'(m_vel));
            chk("cyc_at_speed", longint'(at_speed), longint'(m_at));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_until(input int t);
        int guard;
        guard = 0;
        if (n > t) chk("schedule", longint'(n), longint'(t));
        while (n < t && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (n < t) chk("wait_timeout", longint'(n), longint'(t));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_period", longint'(period), STOP);
        chk("rst_dir", longint'(dir), 0);
        chk("rst_vel", longint'($signed(current_velocity)), 0);
        chk("rst_at_speed", longint'(at_speed), 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    function automatic logic [VB-1:0] rand_target();
        int tv;
        case ($urandom_range(0, 4))
            0:       tv = int'($urandom_range(0, 4000)) - 2000;
            1:       tv = int'($urandom_range(0, 2 * MAXV)) - MAXV;
            2:       tv = ($urandom_range(0, 1) != 0) ? -8388608 : 8388607;
            3:       tv = 0;
            default: tv = int'($urandom);
        endcase
        return VB'(tv);
    endfunction

    function automatic logic [VB-1:0] rand_accel();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return VB'($urandom_range(1, 500));
            2:       return VB'($urandom_range(1, 100000));
            default: return VB'($urandom);
        endcase
    endfunction

    initial begin
        #22 reset = 1'b0;

        // Ramp up 0 -> 1000 at 100 per tick.
        wait_until(RD);          chk("t1_vel_pre", $signed(current_velocity), 0);
        wait_until(RD + 1);      chk("t1_vel1", $signed(current_velocity), 100);
        wait_until(RD + PB + 2); chk("t1_period_hold", period, STOP);
                                 chk("t1_dir_hold", dir, 0);
        wait_until(RD + PB + 3); chk("t1_period1", period, 500000);
                                 chk("t1_dir1", dir, 1);
        wait_until(10*RD + PB + 3);
        chk("t1_vel10", $signed(current_velocity), 1000);
        chk("t1_period10", period, 50000);
        chk("t1_at_speed", at_speed, 1);

        // Reversal through zero.
        wait_until(11*RD + 2);
        target_velocity = VB'(-1000); accel = 24'd300;
        wait_until(15*RD + PB + 3);
        chk("t2_vel0", $signed(current_velocity), 0);
        chk("t2_period0", period, STOP);
        chk("t2_dir_kept", dir, 1);
        wait_until(16*RD + PB + 3);
        chk("t2_vel_neg", $signed(current_velocity), -300);
        chk("t2_dir_neg", dir, 0);
        chk("t2_period_neg", period, 166666);

        // Velocity clamp, both signs.
        wait_until(16*RD + PB + 4);
        target_velocity = 24'd500000; accel = 24'd200000;
        wait_until(18*RD + PB + 3);
        chk("t3_vel_max", $signed(current_velocity), 200000);
        chk("t3_period_min", period, 250);
        wait_until(18*RD + PB + 4);
        target_velocity = 24'h800000;
        wait_until(20*RD + PB + 3);
        chk("t3_vel_min", $signed(current_velocity), -200000);
        chk("t3_period_neg", period, 250);
        chk("t3_dir_neg", dir, 0);
        wait_until(20*RD + PB + 4);
        target_velocity = 24'd1000;

        // Controlled stop on enable drop.
        wait_until(22*RD + 1);
        chk("t4_vel_start", $signed(current_velocity), 1000);
        wait_until(22*RD + 2);
        enable = 1'b0; accel = 24'd250;
        wait_until(25*RD + PB + 3);
        chk("t4_vel250", $signed(current_velocity), 250);
        chk("t4_period250", period, 200000);
        wait_until(26*RD + PB + 3);
        chk("t4_vel0", $signed(current_velocity), 0);
        chk("t4_period_stop", period, STOP);
        chk("t4_at_speed", at_speed, 1);
        chk("t4_dir", dir, 1);

        // Reset in the middle of a divide.
        wait_until(26*RD + PB + 4);
        enable = 1'b1; target_velocity = 24'd50000; accel = 24'd5000;
        wait_until(27*RD + 10);
        chk("t6_vel_before", $signed(current_velocity), 5000);
        do_reset();
        wait_until(RD);          chk("t6_vel_wait", $signed(current_velocity), 0);
        wait_until(RD + 1);      chk("t6_vel_first", $signed(current_velocity), 5000);
        wait_until(RD + PB + 3); chk("t6_period_first", period, 10000);

        // Random commands against the model.
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(1, 90)) @(negedge clk);
            target_velocity = rand_target();
            accel           = rand_accel();
            enable          = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) do_reset();
        end
        repeat (2 * RD) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
